// File: rtl/store_buffer.sv
// Post-execute store queue in front of a single-port data memory.
// Retires stores in program order when the port is free and forwards the youngest match to loads.
module store_buffer #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwriteM,
  input  logic              memreadM,
  input  logic [ADDR_W-1:0] aluresultM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] readdataM,
  output logic              stallM,
  output logic              sb_empty,
  output logic [CNT_W-1:0]  sb_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              push;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == CNT_W'(0));
  assign push  = memwriteM & ~full & ~rst;
  // A store arriving while full lets the oldest entry drain; the store itself is held by the stall.
  assign drain = ~empty & ~memreadM & (~memwriteM | full) & ~rst;

  assign stallM   = memwriteM & full & ~rst;
  assign sb_empty = empty;
  assign sb_count = count;

  // Memory port: drained entry when retiring, otherwise the M-stage address passes through.
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = aluresultM;
    dm_wdata = writedataM;
    if (drain) begin
      dm_we    = 1'b1;
      dm_addr  = addr_q[head];
      dm_wdata = data_q[head];
    end else begin
      dm_we    = 1'b0;
    end
  end

  // Forwarding scan from oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (addr_q[head + PTR_W'(i)] == aluresultM)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head + PTR_W'(i)];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end

  // Load result: buffered data has priority over memory contents.
  always_comb begin
    if (memreadM && fwd_hit) begin
      readdataM = fwd_data;
    end else begin
      readdataM = dm_rdata;
    end
  end

  // Entry storage; contents need no reset since count qualifies validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= aluresultM;
      data_q[tail] <= writedataM;
    end
  end

  // Pointers and occupancy; reset discards every pending store.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      if (push) begin
        count <= count + CNT_W'(1);
      end else if (drain) begin
        count <= count - CNT_W'(1);
      end else begin
        count <= count;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model, directed scenarios
// with literal expectations, then randomized traffic and a final memory image comparison.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        memwriteM;
  logic        memreadM;
  logic [18:0] aluresultM;
  logic [18:0] writedataM;
  logic [18:0] dm_rdata;
  logic        dm_we;
  logic [18:0] dm_addr;
  logic [18:0] dm_wdata;
  logic [18:0] readdataM;
  logic        stallM;
  logic        sb_empty;
  logic [2:0]  sb_count;

  typedef struct {
    logic [18:0] a;
    logic [18:0] d;
  } ent_t;

  ent_t        q[$];
  logic [18:0] env_mem [32];
  logic [18:0] model_mem [32];
  logic        cap_we;
  logic [18:0] cap_addr;
  logic [18:0] cap_wdata;
  int          n_checks;
  int          n_fail;

  store_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .memwriteM  (memwriteM),
    .memreadM   (memreadM),
    .aluresultM (aluresultM),
    .writedataM (writedataM),
    .dm_rdata   (dm_rdata),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .sb_empty   (sb_empty),
    .sb_count   (sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rdata = env_mem[dm_addr[4:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from the queue contents and the current inputs.
  task automatic model_check();
    int          n;
    logic        full;
    logic        exp_drain;
    logic        hit;
    logic [18:0] exp_rd;
    n         = q.size();
    full      = (n == 4);
    exp_drain = (n > 0) && !memreadM && (!memwriteM || full) && !rst;
    chk("dm_we", {31'd0, dm_we}, {31'd0, exp_drain});
    if (exp_drain) begin
      chk("drain_addr", {13'd0, dm_addr}, {13'd0, q[0].a});
      chk("drain_data", {13'd0, dm_wdata}, {13'd0, q[0].d});
    end else begin
      chk("pass_addr", {13'd0, dm_addr}, {13'd0, aluresultM});
    end
    if (!rst) begin
      chk("stallM", {31'd0, stallM}, {31'd0, (memwriteM && full)});
    end
    chk("sb_count", {29'd0, sb_count}, n);
    chk("sb_empty", {31'd0, sb_empty}, {31'd0, (n == 0)});
    if (memreadM && !rst) begin
      hit    = 1'b0;
      exp_rd = model_mem[aluresultM[4:0]];
      for (int i = n - 1; i >= 0; i--) begin
        if (!hit && q[i].a == aluresultM) begin
          hit    = 1'b1;
          exp_rd = q[i].d;
        end
      end
      chk("readdataM", {13'd0, readdataM}, {13'd0, exp_rd});
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic rd,
                       input logic [18:0] a, input logic [18:0] d);
    @(negedge clk);
    rst        = r;
    memwriteM  = w;
    memreadM   = rd;
    aluresultM = a;
    writedataM = d;
    #1;
    model_check();
    cap_we    = dm_we;
    cap_addr  = dm_addr;
    cap_wdata = dm_wdata;
  endtask

  // Advance one edge: environment memory takes the DUT write, model takes the rule-based step.
  task automatic tick();
    logic full;
    logic dr;
    logic ps;
    @(posedge clk);
    if (cap_we) env_mem[cap_addr[4:0]] = cap_wdata;
    if (rst) begin
      q.delete();
    end else begin
      full = (q.size() == 4);
      dr   = (q.size() > 0) && !memreadM && (!memwriteM || full);
      ps   = memwriteM && !full;
      if (dr) begin
        model_mem[q[0].a[4:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (ps) q.push_back('{a: aluresultM, d: writedataM});
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [18:0] a, input logic [18:0] d);
    drive(r, w, rd, a, d);
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    memwriteM  = 1'b0;
    memreadM   = 1'b0;
    aluresultM = 19'd0;
    writedataM = 19'd0;
    cap_we     = 1'b0;
    cap_addr   = 19'd0;
    cap_wdata  = 19'd0;
    for (int i = 0; i < 32; i++) begin
      env_mem[i]   = 19'h00100 + 19'(3 * i);
      model_mem[i] = 19'h00100 + 19'(3 * i);
    end
    @(posedge clk);

    // Reset held two cycles with a store request present.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 19'd9, 19'h00abc);
      chk("rst_we", {31'd0, dm_we}, 32'd0);
      tick();
      #1;
      chk("rst_empty", {31'd0, sb_empty}, 32'd1);
      chk("rst_count", {29'd0, sb_count}, 32'd0);
    end

    // Single store then idle.
    step(1'b0, 1'b1, 1'b0, 19'd5, 19'h00123);
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    chk("single_we", {31'd0, dm_we}, 32'd1);
    chk("single_addr", {13'd0, dm_addr}, 32'd5);
    chk("single_data", {13'd0, dm_wdata}, 32'h00123);
    chk("single_cnt1", {29'd0, sb_count}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    chk("single_cnt0", {29'd0, sb_count}, 32'd0);
    tick();

    // Forwarding of the younger of two stores to one address.
    step(1'b0, 1'b1, 1'b0, 19'd7, 19'h00011);
    step(1'b0, 1'b1, 1'b0, 19'd7, 19'h00022);
    drive(1'b0, 1'b0, 1'b1, 19'd7, 19'd0);
    chk("fwd_data", {13'd0, readdataM}, 32'h00022);
    chk("fwd_we", {31'd0, dm_we}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 19'd8, 19'd0);
    chk("miss_data", {13'd0, readdataM}, 32'h00118);
    tick();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);

    // Full-buffer stall: fifth store stalls one cycle while the oldest entry drains.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 19'(i), 19'h00040 + 19'(i));
    drive(1'b0, 1'b1, 1'b0, 19'd4, 19'h00044);
    chk("full_stall", {31'd0, stallM}, 32'd1);
    chk("full_drain_we", {31'd0, dm_we}, 32'd1);
    chk("full_drain_addr", {13'd0, dm_addr}, 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 19'd4, 19'h00044);
    chk("held_stall", {31'd0, stallM}, 32'd0);
    chk("held_cnt", {29'd0, sb_count}, 32'd3);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
      if (i == 1) chk("after_stall_cnt", {29'd0, sb_count}, 32'd4);
      chk("order_addr", {13'd0, dm_addr}, 32'(i));
      chk("order_data", {13'd0, dm_wdata}, 32'h00040 + 32'(i));
      tick();
    end

    // Alternating store/idle pairs wrap the pointers twice.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 19'd16 + 19'(i), 19'h01000 + 19'(i));
      step(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    chk("wrap_empty", {31'd0, sb_empty}, 32'd1);
    tick();

    // Reset with three stores pending discards them.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 19'd10 + 19'(i), 19'h02000 + 19'(i));
    drive(1'b1, 1'b0, 1'b0, 19'd0, 19'd0);
    chk("rst_mid_we", {31'd0, dm_we}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 19'd10, 19'd0);
    chk("rst_mid_cnt", {29'd0, sb_count}, 32'd0);
    chk("rst_mid_load", {13'd0, readdataM}, 32'h0011e);
    tick();

    // Randomized traffic, small address set with high-bit aliases to exercise full-width compare.
    for (int c = 0; c < 600; c++) begin
      int          op;
      logic [18:0] a;
      op = int'($urandom_range(0, 3));
      a  = 19'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) a = a | 19'h40000;
      if ($urandom_range(0, 63) == 0) begin
        step(1'b1, op[0], 1'b0, a, 19'($urandom));
      end else if (op == 1 || op == 2) begin
        step(1'b0, 1'b1, 1'b0, a, 19'($urandom));
      end else if (op == 3) begin
        step(1'b0, 1'b0, 1'b1, a, 19'd0);
      end else begin
        step(1'b0, 1'b0, 1'b0, a, 19'd0);
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    for (int i = 0; i < 32; i++) begin
      chk("mem_image", {13'd0, env_mem[i]}, {13'd0, model_mem[i]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
